// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that drains the ALU and LSB result FIFOs onto the
// single common data bus, one registered beat per cycle.
module cdb_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int ROB_INDEX_WIDTH = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       rob_clear,
    input  logic                       alu_in_valid,
    input  logic [ROB_INDEX_WIDTH-1:0] alu_in_rob_index,
    input  logic [DATA_WIDTH-1:0]      alu_in_val,
    output logic                       alu_in_ready,
    input  logic                       lsb_in_valid,
    input  logic [ROB_INDEX_WIDTH-1:0] lsb_in_rob_index,
    input  logic [DATA_WIDTH-1:0]      lsb_in_val,
    output logic                       lsb_in_ready,
    output logic                       cdb_valid,
    output logic [ROB_INDEX_WIDTH-1:0] cdb_rob_index,
    output logic [DATA_WIDTH-1:0]      cdb_val,
    output logic                       cdb_src
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_LSB = 1'b1;

    logic [ROB_INDEX_WIDTH-1:0] alu_tag_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]      alu_val_mem [FIFO_DEPTH];
    logic [ROB_INDEX_WIDTH-1:0] lsb_tag_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]      lsb_val_mem [FIFO_DEPTH];

    logic [PTR_W-1:0] alu_head, alu_tail, lsb_head, lsb_tail;
    logic [CNT_W-1:0] alu_count, lsb_count;
    logic             last_grant;

    logic alu_push, lsb_push, alu_pop, lsb_pop;
    logic alu_nonempty, lsb_nonempty, grant_lsb;

    // Readiness looks only at registered occupancy, so a full FIFO refuses
    // a push even when it is being popped in the same cycle.
    assign alu_in_ready = rdy_in && !rst_in && (alu_count != CNT_FULL);
    assign lsb_in_ready = rdy_in && !rst_in && (lsb_count != CNT_FULL);

    // Tag 0 means "no dependency": accept the handshake but never store it.
    assign alu_push = alu_in_valid && alu_in_ready && !rob_clear && (alu_in_rob_index != '0);
    assign lsb_push = lsb_in_valid && lsb_in_ready && !rob_clear && (lsb_in_rob_index != '0);

    assign alu_nonempty = (alu_count != '0);
    assign lsb_nonempty = (lsb_count != '0);
    assign grant_lsb    = lsb_nonempty && (!alu_nonempty || (last_grant == SRC_ALU));
    assign alu_pop      = alu_nonempty && !grant_lsb;
    assign lsb_pop      = grant_lsb;

    always_ff @(posedge clk_in) begin
        if (alu_push) begin
            alu_tag_mem[alu_tail] <= alu_in_rob_index;
            alu_val_mem[alu_tail] <= alu_in_val;
        end
        if (lsb_push) begin
            lsb_tag_mem[lsb_tail] <= lsb_in_rob_index;
            lsb_val_mem[lsb_tail] <= lsb_in_val;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            alu_head      <= '0;
            alu_tail      <= '0;
            alu_count     <= '0;
            lsb_head      <= '0;
            lsb_tail      <= '0;
            lsb_count     <= '0;
            last_grant    <= SRC_LSB;
            cdb_valid     <= 1'b0;
            cdb_rob_index <= '0;
            cdb_val       <= '0;
            cdb_src       <= SRC_ALU;
        end else if (rdy_in) begin
            if (rob_clear) begin
                alu_head   <= '0;
                alu_tail   <= '0;
                alu_count  <= '0;
                lsb_head   <= '0;
                lsb_tail   <= '0;
                lsb_count  <= '0;
                last_grant <= SRC_LSB;
                cdb_valid  <= 1'b0;
            end else begin
                if (alu_push) alu_tail <= alu_tail + PTR_ONE;
                if (lsb_push) lsb_tail <= lsb_tail + PTR_ONE;
                if (alu_pop)  alu_head <= alu_head + PTR_ONE;
                if (lsb_pop)  lsb_head <= lsb_head + PTR_ONE;

                if (alu_push && !alu_pop)      alu_count <= alu_count + CNT_ONE;
                else if (!alu_push && alu_pop) alu_count <= alu_count - CNT_ONE;
                if (lsb_push && !lsb_pop)      lsb_count <= lsb_count + CNT_ONE;
                else if (!lsb_push && lsb_pop) lsb_count <= lsb_count - CNT_ONE;

                cdb_valid <= alu_pop || lsb_pop;
                if (alu_pop) begin
                    cdb_rob_index <= alu_tag_mem[alu_head];
                    cdb_val       <= alu_val_mem[alu_head];
                    cdb_src       <= SRC_ALU;
                    last_grant    <= SRC_ALU;
                end else if (lsb_pop) begin
                    cdb_rob_index <= lsb_tag_mem[lsb_head];
                    cdb_val       <= lsb_val_mem[lsb_head];
                    cdb_src       <= SRC_LSB;
                    last_grant    <= SRC_LSB;
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a queue-based reference model predicts
// every CDB beat with its cycle number; a negedge monitor checks the bus.
module tb_cdb_arbiter;

    localparam int DW    = 32;
    localparam int TW    = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_in = 1'b1, rdy_in = 1'b0, rob_clear = 1'b0;
    logic          alu_in_valid = 1'b0, lsb_in_valid = 1'b0;
    logic [TW-1:0] alu_in_rob_index = '0, lsb_in_rob_index = '0;
    logic [DW-1:0] alu_in_val = '0, lsb_in_val = '0;
    logic          alu_in_ready, lsb_in_ready;
    logic          cdb_valid, cdb_src;
    logic [TW-1:0] cdb_rob_index;
    logic [DW-1:0] cdb_val;

    cdb_arbiter #(.DATA_WIDTH(DW), .ROB_INDEX_WIDTH(TW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
        .alu_in_valid(alu_in_valid), .alu_in_rob_index(alu_in_rob_index),
        .alu_in_val(alu_in_val), .alu_in_ready(alu_in_ready),
        .lsb_in_valid(lsb_in_valid), .lsb_in_rob_index(lsb_in_rob_index),
        .lsb_in_val(lsb_in_val), .lsb_in_ready(lsb_in_ready),
        .cdb_valid(cdb_valid), .cdb_rob_index(cdb_rob_index),
        .cdb_val(cdb_val), .cdb_src(cdb_src)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] val;
    } entry_t;

    typedef struct {
        int            at_cyc;
        logic [TW-1:0] tag;
        logic [DW-1:0] val;
        logic          src;
    } beat_t;

    entry_t aq[$];
    entry_t lq[$];
    beat_t  exp_q[$];
    logic   m_last_lsb = 1'b1;
    logic   m_v = 1'b0, m_src = 1'b0;
    logic [TW-1:0] m_tag = '0;
    logic [DW-1:0] m_val = '0;
    bit     m_known = 1'b0;
    int     total = 0, bad = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every valid bus cycle must match the oldest predicted beat.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].at_cyc < cyc) begin
            chk(1'b0, "missing_beat", 64'(exp_q[0].at_cyc), 64'(exp_q[0].tag));
            void'(exp_q.pop_front());
        end
        if (cdb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_beat", 64'(cdb_rob_index), 64'(0));
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk(e.at_cyc == cyc && cdb_rob_index == e.tag && cdb_val == e.val && cdb_src == e.src,
                    "cdb_beat", {cdb_src, 7'(cyc), 20'(cdb_rob_index), 32'(cdb_val)},
                    {e.src, 7'(e.at_cyc), 20'(e.tag), 32'(e.val)});
            end
        end
    end

    // One clock of stimulus plus the reference model's view of that edge.
    task automatic step(input bit r, input bit rd, input bit cl,
                        input bit av, input logic [TW-1:0] at, input logic [DW-1:0] avl,
                        input bit lv, input logic [TW-1:0] lt, input logic [DW-1:0] lvl);
        bit exp_ar, exp_lr;
        entry_t e;
        @(posedge clk);
        #1;
        if (m_known) begin
            chk(cdb_rob_index == m_tag, "cdb_rob_index_reg", 64'(cdb_rob_index), 64'(m_tag));
            chk(cdb_val == m_val, "cdb_val_reg", 64'(cdb_val), 64'(m_val));
            chk(cdb_src == m_src, "cdb_src_reg", 64'(cdb_src), 64'(m_src));
        end
        rst_in = r; rdy_in = rd; rob_clear = cl;
        alu_in_valid = av; alu_in_rob_index = at; alu_in_val = avl;
        lsb_in_valid = lv; lsb_in_rob_index = lt; lsb_in_val = lvl;
        #1;
        exp_ar = !r && rd && (aq.size() < DEPTH);
        exp_lr = !r && rd && (lq.size() < DEPTH);
        if (m_known || r) begin
            chk(alu_in_ready == exp_ar, "alu_in_ready", 64'(alu_in_ready), 64'(exp_ar));
            chk(lsb_in_ready == exp_lr, "lsb_in_ready", 64'(lsb_in_ready), 64'(exp_lr));
        end
        if (r) begin
            aq.delete(); lq.delete();
            m_last_lsb = 1'b1; m_v = 1'b0; m_tag = '0; m_val = '0; m_src = 1'b0;
            m_known = 1'b1;
        end else if (!rd) begin
            if (m_v) exp_q.push_back('{cyc + 1, m_tag, m_val, m_src});
        end else if (cl) begin
            aq.delete(); lq.delete();
            m_last_lsb = 1'b1; m_v = 1'b0;
        end else begin
            m_v = 1'b0;
            if (aq.size() > 0 && (lq.size() == 0 || m_last_lsb)) begin
                e = aq.pop_front();
                m_v = 1'b1; m_tag = e.tag; m_val = e.val; m_src = 1'b0; m_last_lsb = 1'b0;
            end else if (lq.size() > 0) begin
                e = lq.pop_front();
                m_v = 1'b1; m_tag = e.tag; m_val = e.val; m_src = 1'b1; m_last_lsb = 1'b1;
            end
            if (av && exp_ar && at != 0) aq.push_back('{at, avl});
            if (lv && exp_lr && lt != 0) lq.push_back('{lt, lvl});
            if (m_v) exp_q.push_back('{cyc + 1, m_tag, m_val, m_src});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, '0, '0, 0, '0, '0);
    endtask

    initial begin
        step(1, 0, 0, 0, '0, '0, 0, '0, '0);
        step(1, 1, 0, 0, '0, '0, 0, '0, '0);
        idle(2);

        step(0, 1, 0, 1, 4'd3, 32'h0000_00AA, 0, '0, '0);
        idle(4);

        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 4'd5, 32'h11, 1, 4'd6, 32'h22);
        idle(8);

        for (int i = 0; i < 8; i++)
            step(0, !(i == 3 || i == 4), 0, 1, 4'(1 + i), 32'(32'hA00 + i),
                 (i < 6), 4'(9 + i), 32'(32'hB00 + i));
        idle(12);

        for (int i = 0; i < 6; i++) step(0, 1, 0, 1, 4'(2 + i), 32'(32'hC00 + i), 1, 4'd7, 32'(32'hD00 + i));
        step(0, 1, 1, 1, 4'd4, 32'h44, 1, 4'd4, 32'h44);
        step(0, 1, 0, 1, 4'd9, 32'h99, 0, '0, '0);
        idle(6);

        step(0, 1, 0, 0, '0, '0, 1, 4'd0, 32'h1234);
        idle(4);

        for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 4'(3 + i), 32'(32'hE00 + i), 1, 4'(8 + i), 32'(32'hF00 + i));
        step(1, 1, 0, 1, 4'd2, 32'h2, 1, 4'd2, 32'h2);
        idle(6);

        for (int i = 0; i < 700; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 9) < 6), 4'($urandom_range(0, 15)), 32'($urandom),
                 ($urandom_range(0, 9) < 6), 4'($urandom_range(0, 15)), 32'($urandom));
        end
        idle(16);
        @(negedge clk);
        chk(exp_q.size() == 0, "scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
